// File: rtl/vec_write_queue.sv
// vec_write_queue
//   Buffers vector-write commands (register index + vector) coming from the
//   memory-mapped vector-assembly stage. It presents them to the vector
//   register file write port through a first-word-fall-through valid/ready
//   interface.
//
//   The upstream strobe stays high for as long as the trigger address is held.
//   One write event is therefore produced per rising strobe or per address
//   change while the strobe is high.
//
//   Optional build macro: VQ_COALESCE_EN
//     When defined, a legal event whose index matches the tail-most queued
//     entry overwrites that entry's data in place instead of pushing.
//
// Ports
//   clk       in   system clock, posedge
//   rst_n     in   synchronous active-low reset
//   vecWrite  in   write strobe (level, edge-detected here)
//   vecAddr   in   target vector register index
//   vector    in   vector data, qualified by vecWrite
//   wrValid   out  head entry valid
//   wrReady   in   register file accepts head
//   wrIdx     out  head register index (0 while !wrValid)
//   wrData    out  head vector data (0 while !wrValid)
//   count     out  occupancy
//   full      out  count == DEPTH
//   overflow  out  sticky: legal write dropped because queue was full
//   badAddr   out  sticky: write dropped because vecAddr >= NUM_VREGS
//   clrErr    in   clears overflow / badAddr (a same-cycle set wins)
module vec_write_queue #(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 16,
    parameter int IDX_W     = 2,
    parameter int NUM_VREGS = 3,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       vecWrite,
    input  logic [ADDR_W-1:0]          vecAddr,
    input  logic [DATA_W-1:0]          vector,
    output logic                       wrValid,
    input  logic                       wrReady,
    output logic [IDX_W-1:0]           wrIdx,
    output logic [DATA_W-1:0]          wrData,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow,
    output logic                       badAddr,
    input  logic                       clrErr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     cnt;
    logic              vecWrite_q;
    logic [ADDR_W-1:0] vecAddr_q;

    logic evt, legal, pop, push, coal, ovf_set, bad_set;

    assign wrValid = (cnt != '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign wrIdx   = wrValid ? mem[head].idx  : '0;
    assign wrData  = wrValid ? mem[head].data : '0;

    // A held strobe only fires again if the address changes under it.
    assign evt   = vecWrite & (~vecWrite_q | (vecAddr != vecAddr_q));
    assign legal = (vecAddr < ADDR_W'(NUM_VREGS));
    assign pop   = wrValid & wrReady;

`ifdef VQ_COALESCE_EN
    logic [PW-1:0] tail_last;
    assign tail_last = tail - PW'(1);
    // A single entry that is leaving this cycle cannot absorb the write;
    // that case falls back to a normal push.
    assign coal = evt & legal & wrValid
                & (mem[tail_last].idx == vecAddr[IDX_W-1:0])
                & ~((cnt == CW'(1)) & pop);
`else
    assign coal = 1'b0;
`endif

    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign push    = evt & legal & ~coal & (~full | pop);
    assign ovf_set = evt & legal & ~coal & ~push;
    assign bad_set = evt & ~legal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
            vecWrite_q <= 1'b0;
            vecAddr_q  <= '0;
            overflow   <= 1'b0;
            badAddr    <= 1'b0;
        end else begin
            vecWrite_q <= vecWrite;
            vecAddr_q  <= vecAddr;
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            overflow <= ovf_set | (overflow & ~clrErr);
            badAddr  <= bad_set | (badAddr  & ~clrErr);
        end
    end

    // Entry storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (push) mem[tail] <= '{idx: vecAddr[IDX_W-1:0], data: vector};
`ifdef VQ_COALESCE_EN
            else if (coal) mem[tail_last].data <= vector;
`endif
        end
    end

endmodule

// File: tb/tb_vec_write_queue.sv
module tb_vec_write_queue;
    localparam int DEPTH = 4;
    localparam int NV    = 3;

    logic         clk = 1'b0;
    logic         rst_n, vecWrite, wrReady, clrErr;
    logic [15:0]  vecAddr;
    logic [255:0] vector;
    logic         wrValid, full, overflow, badAddr;
    logic [1:0]   wrIdx;
    logic [255:0] wrData;
    logic [2:0]   count;

    vec_write_queue dut (
        .clk(clk), .rst_n(rst_n), .vecWrite(vecWrite), .vecAddr(vecAddr),
        .vector(vector), .wrValid(wrValid), .wrReady(wrReady), .wrIdx(wrIdx),
        .wrData(wrData), .count(count), .full(full), .overflow(overflow),
        .badAddr(badAddr), .clrErr(clrErr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] idx; logic [255:0] data; } ent_t;
    ent_t        mq[$];
    logic        m_pw, m_ovf, m_bad;
    logic [15:0] m_pa;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: queue semantics straight from the rules.
    task automatic model(input logic vw, input logic [15:0] va, input logic [255:0] d,
                         input logic rdy, input logic clr, input logic rs);
        logic pop, ev, oset, bset, coal;
        ent_t e;
        if (!rs) begin
            mq.delete(); m_pw = 0; m_pa = 0; m_ovf = 0; m_bad = 0;
            return;
        end
        pop  = (mq.size() != 0) && rdy;
        ev   = vw && (!m_pw || va != m_pa);
        oset = 0; bset = 0; coal = 0;
        if (ev && va >= NV) bset = 1;
`ifdef VQ_COALESCE_EN
        if (ev && va < NV && mq.size() != 0 && mq[$].idx == va[1:0] &&
            !(mq.size() == 1 && pop)) begin
            coal = 1;
            mq[$].data = d;
        end
`endif
        if (pop) void'(mq.pop_front());
        if (ev && va < NV && !coal) begin
            if (mq.size() < DEPTH) begin
                e.idx = va[1:0]; e.data = d; mq.push_back(e);
            end else oset = 1;
        end
        m_ovf = oset | (m_ovf & !clr);
        m_bad = bset | (m_bad & !clr);
        m_pw = vw; m_pa = va;
    endtask

    task automatic cycle(input logic vw, input logic [15:0] va, input logic [255:0] d,
                         input logic rdy, input logic clr, input logic rs);
        logic v;
        vecWrite = vw; vecAddr = va; vector = d; wrReady = rdy; clrErr = clr; rst_n = rs;
        model(vw, va, d, rdy, clr, rs);
        @(posedge clk); #1;
        v = (mq.size() != 0);
        chk("wrValid",  {255'b0, wrValid},  {255'b0, v});
        chk("wrIdx",    {254'b0, wrIdx},    {254'b0, v ? mq[0].idx : 2'b0});
        chk("wrData",   wrData,             v ? mq[0].data : 256'b0);
        chk("count",    {253'b0, count},    256'(mq.size()));
        chk("full",     {255'b0, full},     {255'b0, mq.size() == DEPTH});
        chk("overflow", {255'b0, overflow}, {255'b0, m_ovf});
        chk("badAddr",  {255'b0, badAddr},  {255'b0, m_bad});
    endtask

    task automatic ev(input logic [15:0] a, input logic [255:0] d, input logic rdy);
        cycle(1, a, d, rdy, 0, 1);
        cycle(0, a, d, rdy, 0, 1);
    endtask

    initial begin
        logic [255:0] a5, d1, d2;
        a5 = {32{8'hA5}};
        d1 = rnd256(); d2 = rnd256();
        m_pw = 0; m_pa = 0; m_ovf = 0; m_bad = 0;

        // reset state
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // held strobe -> single event, FWFT latency 1
        cycle(1, 1, a5, 0, 0, 1);
        chk("lat1_valid", {255'b0, wrValid}, 256'd1);
        for (int i = 0; i < 4; i++) cycle(1, 1, a5, 0, 0, 1);
        chk("hold_count", {253'b0, count}, 256'd1);
        chk("hold_idx",   {254'b0, wrIdx}, 256'd1);
        chk("hold_data",  wrData, a5);

        // fill, overflow, drain in order
        cycle(0, 0, 0, 0, 0, 0);
        ev(0, rnd256(), 0); ev(1, rnd256(), 0); ev(2, rnd256(), 0); ev(0, rnd256(), 0);
        ev(1, rnd256(), 0);
        chk("ovf_flag",  {255'b0, overflow}, 256'd1);
        chk("ovf_count", {253'b0, count},    256'd4);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 0, 1);
        chk("drained", {255'b0, wrValid}, 256'd0);

        // full + pop + push same cycle
        ev(0, rnd256(), 0); ev(1, rnd256(), 0); ev(2, rnd256(), 0); ev(0, rnd256(), 0);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(1, 1, rnd256(), 1, 0, 1);
        chk("fullpp_count", {253'b0, count},    256'd4);
        chk("fullpp_ovf",   {255'b0, overflow}, 256'd0);

        // bad address, then clear
        cycle(0, 3, 0, 0, 0, 1);
        cycle(1, 3, rnd256(), 0, 0, 1);
        chk("bad_flag",  {255'b0, badAddr}, 256'd1);
        chk("bad_count", {253'b0, count},   256'd4);
        cycle(0, 3, 0, 0, 1, 1);
        chk("bad_clr", {255'b0, badAddr}, 256'd0);

        // stall stability, then reset mid-stream
        for (int i = 0; i < 3; i++) cycle(0, 0, rnd256(), 0, 0, 1);
        cycle(1, 2, rnd256(), 1, 0, 0);
        chk("rst_count", {253'b0, count}, 256'd0);
        chk("rst_data",  wrData, 256'd0);

        // same index twice
        cycle(0, 0, 0, 0, 0, 1);
        ev(2, d1, 0); ev(2, d2, 0);
`ifdef VQ_COALESCE_EN
        chk("coal_count", {253'b0, count}, 256'd1);
        chk("coal_data",  wrData, d2);
`else
        chk("nocoal_count", {253'b0, count}, 256'd2);
        chk("nocoal_data",  wrData, d1);
`endif
        cycle(0, 2, 0, 1, 0, 1);
        cycle(0, 2, 0, 1, 0, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4));
            cycle($urandom_range(0, 1) == 1, a, rnd256(), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 60) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vec_write_queue.md
Name: vec_write_queue

Overview:
- Buffers completed vector-write commands (register index + 256-bit vector) produced by the memory-mapped vector-assembly stage, and delivers them to the vector register file write port.
- Uses a valid/ready handshake, so the scalar core can issue vector writes while the vector datapath is stalled.
- Sits between the vector-assembly stage (vecWrite/vecAddr/vector) and the vector register file write port.
- Also performs edge detection, because the upstream vecWrite stays high for as long as the trigger address is held.

Parameters:
- DATA_W, 256, vector width in bits
- ADDR_W, 16, width of the incoming vecAddr
- IDX_W, 2, width of the register index sent to the register file
- NUM_VREGS, 3, number of valid vector registers; legal indices are 0..NUM_VREGS-1
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2

Ports:
- clk  in  1  system clock; all logic is on posedge
- rst_n  in  1  synchronous, active-low reset
- vecWrite  in  1  write strobe from the assembly stage; may stay high for several cycles
- vecAddr  in  ADDR_W  target vector register index
- vector  in  DATA_W  vector data; valid in the same cycle as vecWrite
- wrValid  out  1  queue head is valid
- wrReady  in  1  register file accepts the head this cycle
- wrIdx  out  IDX_W  head register index
- wrData  out  DATA_W  head vector data
- count  out  $clog2(DEPTH+1)  current occupancy
- full  out  1  count == DEPTH
- overflow  out  1  sticky flag: a write was dropped because the queue was full
- badAddr  out  1  sticky flag: a write was dropped because vecAddr >= NUM_VREGS
- clrErr  in  1  clears overflow and badAddr

Behaviour:
- Reset (rst_n=0 at posedge): pointers, count, vecWrite_q, vecAddr_q, overflow and badAddr are cleared. Outputs then read wrValid=0, wrIdx=0, wrData=0, count=0, full=0. The entry array is not reset. A reset mid-transfer discards all entries, and no handshake completes in that cycle.
- Write event: vecWrite & (!vecWrite_q | vecAddr != vecAddr_q). vecWrite_q and vecAddr_q are registered copies of the inputs. A write held high with the same address produces exactly one event.
- Event with vecAddr >= NUM_VREGS: dropped; badAddr is set.
- Event with a legal address: if the queue is not full, or a pop occurs in the same cycle, the entry {vecAddr[IDX_W-1:0], vector} is written at the tail and the tail advances modulo DEPTH. Otherwise the entry is dropped and overflow is set.
- Pop: wrValid & wrReady. The head advances modulo DEPTH.
- Occupancy update: count increments on push-only, decrements on pop-only, and is unchanged when push and pop happen together.
- Head presentation: first-word-fall-through. wrValid = (count != 0).
- While wrValid=0, wrIdx and wrData are forced to 0.
- Push-to-wrValid latency is 1 cycle when the queue is empty.
- Handshake rules:
  - wrIdx and wrData are stable while wrValid=1 and wrReady=0.
  - wrValid never drops without a pop.
  - wrReady while empty has no effect.
- Flag priority: if a flag sets in the same cycle that clrErr=1, set wins.
- Pointers are log2(DEPTH) bits. Full and empty are derived from count, not from pointer comparison.

Optional Feature:
- Macro: VQ_COALESCE_EN.
- When defined: a legal event whose index equals the tail-most queued entry's index overwrites that entry's data in place. No push occurs, count is unchanged, and this is allowed even when full.
- Exception: when count==1 and that entry is popped in the same cycle, the event is treated as a normal push.
- When not defined: every legal event pushes a new entry, as specified above.

Test Plan:
- Reset, then vecWrite=1 held for 5 cycles with vecAddr=1, vector=256'hA5.. and wrReady=0 → count=1, wrValid=1 one cycle after the first event, wrIdx=1, wrData=A5...
- 4 events to idx 0,1,2,0 with wrReady=0 (DEPTH=4), then a 5th event → full=1, overflow=1, count=4. Then set wrReady=1 → pops occur in order 0,1,2,0 and wrValid=0 after 4 cycles.
- Queue full, wrReady=1 and a new event in the same cycle → push accepted, count stays 4, overflow stays 0.
- Event with vecAddr=3 → badAddr=1 and count unchanged. Pulse clrErr=1 → badAddr=0.
- Hold wrReady=0 for 3 cycles with wrValid=1 → wrIdx and wrData are unchanged. Assert rst_n=0 mid-stream → next cycle count=0, wrValid=0, wrData=0.
- With VQ_COALESCE_EN: events idx2/D1 then idx2/D2, with wrReady=0 → count=1 and the popped data is D2. Without the macro: count=2 and pops return D1 then D2.
